// File: rtl/instr_encoder.sv
// Instruction encoder: accepts a field bundle, packs it into a 32-bit MIPS-like
// word and writes it to instruction memory at an auto-incrementing pointer.
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op,
    input  logic [4:0]  dst,
    input  logic [4:0]  src1,
    input  logic [4:0]  src2,
    input  logic [25:0] imm,
    input  logic        addr_load,
    input  logic [7:0]  load_addr,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic        err,
    output logic        wrapped,
    output logic [8:0]  word_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        WR   = 2'd2
    } state_t;

    state_t       state_r;
    state_t       state_s;
    logic         accept_s;
    logic         load_s;
    logic [3:0]   op_r;
    logic [4:0]   dst_r;
    logic [4:0]   src1_r;
    logic [4:0]   src2_r;
    logic [25:0]  imm_r;
    logic [31:0]  word_r;
    logic [7:0]   ptr_r;

    function automatic logic op_illegal(input logic [3:0] o);
        return (o > 4'd10);
    endfunction

    function automatic logic [31:0] encode_word(
        input logic [3:0]  o,
        input logic [4:0]  d,
        input logic [4:0]  s1,
        input logic [4:0]  s2,
        input logic [25:0] im
    );
        logic [31:0] w;
        case (o)
            4'd0:    w = {6'd12, s1, s2, d, 5'd0, 6'd32};
            4'd1:    w = {6'd12, s1, s2, d, 5'd0, 6'd34};
            4'd2:    w = {6'd12, s1, s2, d, 5'd0, 6'd50};
            4'd3:    w = {6'd12, s1, s2, d, 5'd0, 6'd36};
            4'd4:    w = {6'd12, s1, s2, d, 5'd0, 6'd37};
            4'd5:    w = {6'd34, s1, d, im[15:0]};
            4'd6:    w = {6'd35, s1, s2, im[15:0]};
            4'd7:    w = {6'd36, s1, s2, im[15:0]};
            4'd8:    w = {6'd37, s1, d, im[15:0]};
            4'd9:    w = {6'd38, s1, d, im[15:0]};
            4'd10:   w = {6'd2, im};
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, handshake and address-load decode
    always_comb begin
        state_s  = state_r;
        in_ready = 1'b0;
        accept_s = 1'b0;
        load_s   = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready = !addr_load;
                load_s   = addr_load;
                accept_s = in_valid && !addr_load;
                state_s  = accept_s ? ENC : IDLE;
            end
            ENC:     state_s = op_illegal(op_r) ? IDLE : WR;
            WR:      state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Field capture, encoding, memory write and status bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r       <= 4'd0;
            dst_r      <= 5'd0;
            src1_r     <= 5'd0;
            src2_r     <= 5'd0;
            imm_r      <= 26'd0;
            word_r     <= 32'd0;
            ptr_r      <= 8'd0;
            mem_we     <= 1'b0;
            mem_addr   <= 8'd0;
            mem_wdata  <= 32'd0;
            err        <= 1'b0;
            wrapped    <= 1'b0;
            word_count <= 9'd0;
        end else begin
            mem_we <= 1'b0;
            err    <= 1'b0;
            if (accept_s) begin
                op_r   <= op;
                dst_r  <= dst;
                src1_r <= src1;
                src2_r <= src2;
                imm_r  <= imm;
                // err is registered at acceptance so it is visible during ENC
                err    <= op_illegal(op);
            end
            if (load_s) begin
                ptr_r <= load_addr;
            end
            if (state_r == ENC) begin
                word_r <= encode_word(op_r, dst_r, src1_r, src2_r, imm_r);
            end
            if (state_r == WR) begin
                mem_we    <= 1'b1;
                mem_addr  <= ptr_r;
                mem_wdata <= word_r;
                ptr_r     <= ptr_r + 8'd1;
                if (ptr_r == 8'd255) begin
                    wrapped <= 1'b1;
                end
                if (word_count != 9'd511) begin
                    word_count <= word_count + 9'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors, a transaction-level
// expectation model checked every cycle, plus literal spot checks.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'd0;
    logic [4:0]  dst = 5'd0;
    logic [4:0]  src1 = 5'd0;
    logic [4:0]  src2 = 5'd0;
    logic [25:0] imm = 26'd0;
    logic        addr_load = 1'b0;
    logic [7:0]  load_addr = 8'd0;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        err;
    logic        wrapped;
    logic [8:0]  word_count;

    instr_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .dst(dst), .src1(src1), .src2(src2), .imm(imm),
        .addr_load(addr_load), .load_addr(load_addr),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .err(err), .wrapped(wrapped), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    bit          started = 1'b0;
    int          idle_from = 0;
    int          err_cyc = -1;
    int          m_ptr = 0;
    int          m_count = 0;
    bit          m_wrapped = 1'b0;
    logic [31:0] m_wdata = 32'd0;
    logic [7:0]  m_addr = 8'd0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, expv);
        end
    endtask

    // Expected word from opcode/funct tables and field positions
    function automatic logic [31:0] model_word(input int o, input int d, input int s1,
                                               input int s2, input longint im);
        int     r_funct[5] = '{32, 34, 50, 36, 37};
        int     i_opc[11]  = '{12, 12, 12, 12, 12, 34, 35, 36, 37, 38, 2};
        longint w;
        longint lo16;
        lo16 = im % 65536;
        if (o <= 4)
            w = i_opc[o] * 64'd67108864 + s1 * 2097152 + s2 * 65536 + d * 2048 + r_funct[o];
        else if (o == 5 || o == 8 || o == 9)
            w = i_opc[o] * 64'd67108864 + s1 * 2097152 + d * 65536 + lo16;
        else if (o == 6 || o == 7)
            w = i_opc[o] * 64'd67108864 + s1 * 2097152 + s2 * 65536 + lo16;
        else
            w = 2 * 64'd67108864 + (im % 67108864);
        return w[31:0];
    endfunction

    // Drive one cycle of inputs, then update the model for the edge that consumes them
    task automatic step(input bit r, input bit v, input bit l, input int la,
                        input int o, input int d, input int s1, input int s2, input longint im);
        int  n;
        bit  idle;
        rst = r; in_valid = v; addr_load = l; load_addr = la[7:0];
        op = o[3:0]; dst = d[4:0]; src1 = s1[4:0]; src2 = s2[4:0]; imm = im[25:0];
        @(posedge clk);
        #1;
        n = cyc;
        idle = ((n - 1) >= idle_from);
        if (r) begin
            exp_q.delete();
            m_ptr = 0; m_count = 0; m_wrapped = 1'b0;
            m_wdata = 32'd0; m_addr = 8'd0;
            err_cyc = -1; idle_from = n;
            started = 1'b1;
        end else if (idle && l) begin
            m_ptr = la % 256;
        end else if (idle && v) begin
            if (o > 10) begin
                err_cyc = n;
                idle_from = n + 1;
            end else begin
                exp_q.push_back('{c: n + 2, a: m_ptr[7:0], d: model_word(o, d, s1, s2, im)});
                m_ptr = (m_ptr + 1) % 256;
                idle_from = n + 2;
            end
        end
    endtask

    task automatic idle_n(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic send(input int o, input int d, input int s1, input int s2, input longint im);
        step(1'b0, 1'b1, 1'b0, 0, o, d, s1, s2, im);
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (started) begin
            bit exp_we;
            exp_we = (exp_q.size() > 0) && (exp_q[0].c == cyc);
            check("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
            if (exp_we) begin
                m_wdata = exp_q[0].d;
                m_addr = exp_q[0].a;
                if (exp_q[0].a == 8'd255) m_wrapped = 1'b1;
                if (m_count < 511) m_count++;
                void'(exp_q.pop_front());
            end
            check("mem_addr", {24'd0, mem_addr}, {24'd0, m_addr});
            check("mem_wdata", mem_wdata, m_wdata);
            check("err", {31'd0, err}, {31'd0, (cyc == err_cyc)});
            check("wrapped", {31'd0, wrapped}, {31'd0, m_wrapped});
            check("word_count", {23'd0, word_count}, m_count);
            check("in_ready", {31'd0, in_ready}, {31'd0, (!addr_load && cyc >= idle_from)});
        end
    end

    initial begin
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
        step(1'b1, 1'b1, 1'b0, 0, 0, 1, 1, 1, 0);
        check("reset_ready", {31'd0, in_ready}, 32'd1);
        check("reset_count", {23'd0, word_count}, 32'd0);

        // add r3 = r1 + r2
        send(0, 3, 1, 2, 0);
        idle_n(2);
        check("add_word", mem_wdata, 32'h30221820);
        check("add_addr", {24'd0, mem_addr}, 32'd0);
        check("add_we", {31'd0, mem_we}, 32'd1);
        check("add_count", {23'd0, word_count}, 32'd1);
        idle_n(1);

        // mul then lw, lw held valid while busy
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
        send(2, 9, 8, 10, 0);
        send(5, 5, 4, 0, 8);
        send(5, 5, 4, 0, 8);
        send(5, 5, 4, 0, 8);
        check("mul_word", mem_wdata, 32'h310A4832);
        idle_n(2);
        check("lw_word", mem_wdata, 32'h88850008);
        check("lw_addr", {24'd0, mem_addr}, 32'd1);

        // ori with oversized immediate, then jmp
        send(9, 7, 6, 0, 64'h3FFFFFF);
        idle_n(2);
        check("ori_word", mem_wdata, 32'h98C7FFFF);
        send(10, 0, 0, 0, 64'h40);
        idle_n(2);
        check("jmp_word", mem_wdata, 32'h08000040);

        // illegal op
        send(13, 1, 1, 1, 1);
        check("illegal_err", {31'd0, err}, 32'd1);
        idle_n(1);
        check("illegal_err_clr", {31'd0, err}, 32'd0);
        check("illegal_ready", {31'd0, in_ready}, 32'd1);
        check("illegal_count", {23'd0, word_count}, 32'd4);

        // remaining ops, with addr_load ignored during ENC
        send(1, 4, 5, 6, 0);
        step(1'b0, 1'b0, 1'b1, 128, 0, 0, 0, 0, 0);
        idle_n(1);
        send(3, 31, 30, 29, 0); idle_n(2);
        send(4, 1, 2, 3, 0);    idle_n(2);
        send(8, 2, 3, 0, 64'h1234); idle_n(2);
        send(6, 9, 1, 2, 64'hFFFC); idle_n(2);
        check("ptr_after_ignored_load", {24'd0, mem_addr}, 32'd8);

        // addr_load beats in_valid, then wrap
        step(1'b0, 1'b1, 1'b1, 255, 7, 0, 3, 4, 16);
        send(6, 0, 3, 4, 16); idle_n(2);
        check("wrap_addr", {24'd0, mem_addr}, 32'd255);
        check("wrap_flag", {31'd0, wrapped}, 32'd1);
        send(7, 0, 5, 6, 64'hFFFF); idle_n(2);
        check("after_wrap_addr", {24'd0, mem_addr}, 32'd0);
        step(1'b0, 1'b0, 1'b1, 17, 0, 0, 0, 0, 0);
        check("load_keeps_wrap", {31'd0, wrapped}, 32'd1);

        // reset during ENC aborts the write
        send(0, 1, 2, 3, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
        check("abort_we", {31'd0, mem_we}, 32'd0);
        check("abort_wdata", mem_wdata, 32'd0);
        check("abort_wrapped", {31'd0, wrapped}, 32'd0);
        idle_n(1);
        check("abort_no_we", {31'd0, mem_we}, 32'd0);
        send(1, 1, 2, 3, 0); idle_n(2);
        check("post_abort_addr", {24'd0, mem_addr}, 32'd0);
        check("post_abort_we", {31'd0, mem_we}, 32'd1);

        // saturation of word_count
        for (int i = 0; i < 514; i++) begin
            send(i % 11, i % 32, (i + 1) % 32, (i + 2) % 32, i * 977);
            idle_n(2);
        end
        check("sat_count", {23'd0, word_count}, 32'd511);
        idle_n(2);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports in this order:
  - clk  in  1  rising-edge clock.
  - rst  in  1  synchronous, active-high reset.
REQ-002 The block SHALL have these handshake and field inputs:
  - in_valid  in  1  field bundle valid.
  - in_ready  out  1  block can accept a bundle.
  - op  in  4  mnemonic: 0 add, 1 sub, 2 mul, 3 and, 4 or, 5 lw, 6 sw, 7 bne, 8 addi, 9 ori, 10 jmp; 11-15 illegal.
  - dst  in  5  destination register.
  - src1  in  5  first source / base register.
  - src2  in  5  second source / store-data register.
  - imm  in  26  immediate; bits [15:0] for I-type, [25:0] for jmp.
REQ-003 The block SHALL have these address-load inputs:
  - addr_load  in  1  load the write pointer.
  - load_addr  in  8  new write pointer value.
REQ-004 The block SHALL have these memory-write and status outputs:
  - mem_we  out  1  instruction-memory write strobe.
  - mem_addr  out  8  write address.
  - mem_wdata  out  32  encoded instruction word.
  - err  out  1  one-cycle pulse on an illegal op.
  - wrapped  out  1  sticky flag: pointer wrapped from 255 to 0.
  - word_count  out  9  count of words written, saturating.

Function
REQ-005 Field placement SHALL be: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6] = 0, funct [5:0]; I-type immediate [15:0]; jmp target [25:0].
REQ-006 R-type ops SHALL use opcode 12, rs=src1, rt=src2, rd=dst, with funct add=32, sub=34, mul=50, and=36, or=37.
REQ-007 lw (34), addi (37) and ori (38) SHALL encode rs=src1, rt=dst, imm[15:0].
REQ-008 sw (35) and bne (36) SHALL encode rs=src1, rt=src2, imm[15:0]; dst is ignored.
REQ-009 jmp SHALL encode opcode 2 in [31:26] and imm[25:0] in [25:0].
REQ-010 The block SHALL use a three-state FSM with states IDLE, ENC and WR.
REQ-011 IDLE SHALL drive in_ready = !addr_load.
REQ-012 A bundle SHALL be accepted when in_valid && in_ready; all fields are registered and the FSM moves to ENC.
REQ-013 ENC SHALL compute the word into a register and move to WR; an illegal op instead pulses err for that cycle and returns to IDLE with no write.
REQ-014 WR SHALL assert mem_we for exactly one cycle, with mem_addr = pointer and mem_wdata = the word.
REQ-015 On leaving WR, the pointer SHALL increment and word_count SHALL increment, saturating at 511; the FSM returns to IDLE.
REQ-016 Latency: a bundle accepted at edge N SHALL produce mem_we high in the cycle after edge N+2; sustained throughput is one word per 3 cycles.
REQ-017 Pointer wrap: an increment from 255 SHALL yield 0 and set wrapped; wrapped stays set until reset.
REQ-018 addr_load SHALL be honoured only in IDLE, and SHALL win over a simultaneous in_valid, which is not accepted that cycle.
REQ-019 addr_load asserted in ENC or WR SHALL be ignored.
REQ-020 addr_load SHALL NOT alter wrapped or word_count.
REQ-021 mem_wdata SHALL hold its last value outside WR; mem_we and err SHALL be 0 outside their defined cycles.
REQ-022 in_ready SHALL be 0 in ENC and WR; in_valid in those states has no effect.

Reset
REQ-023 When rst is sampled high, the FSM SHALL go to IDLE and pointer, mem_addr, mem_wdata, word_count, wrapped, mem_we and err SHALL clear to 0.
REQ-024 Reset SHALL take priority over all other inputs.
REQ-025 Reset in ENC or WR SHALL abort the bundle with no mem_we in the following cycle.
REQ-026 After reset deasserts, in_ready SHALL be 1 in the next cycle (when addr_load is 0).

Verification
REQ-027 add dst=3, src1=1, src2=2 -> mem_wdata 0x30221820 at mem_addr 0, mem_we high 2 cycles after acceptance, word_count 1.
REQ-028 mul dst=9, src1=8, src2=10, then lw dst=5, src1=4, imm=8 -> 0x310A4832 at address 0, then 0x88850008 at address 1.
REQ-029 ori dst=7, src1=6, imm=0x3FFFFFF -> 0x98C7FFFF (imm[25:16] ignored); jmp imm=0x40 -> 0x08000040.
REQ-030 op=13 -> err pulse in the ENC cycle, no mem_we, pointer and word_count unchanged, in_ready back to 1 the next cycle.
REQ-031 addr_load with load_addr=255 together with in_valid -> the bundle is not accepted that cycle; the next bundle is written at 255, then the pointer becomes 0 and wrapped=1.
REQ-032 rst asserted in the ENC cycle -> no mem_we, all outputs 0, and a subsequent bundle is written at address 0.
